sram_banked_dp: RTL and testbench

Parametrised logical dual-port SRAM built from `NUM_BANKS` single-port (1RW) bank macros, address-interleaved on the low word-address bits. It is the successor to the fixed-size dual-port data/instruction SRAM wrappers and gives the TPU core one shape for any width and depth. Bank conflicts between the two ports are resolved with a request/grant handshake and alternating priority. Each bank is a behavioural model in simulation and is replaced by a hardened macro in PnR.

---
 rtl/sram_pkg.sv | 29 ++
 rtl/sram_1rw_bank.sv | 46 ++++
 rtl/sram_banked_dp.sv | 143 ++++++++++++++
 tb/tb_sram_banked_dp.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared definitions for the banked dual-port SRAM.
//   bank_sel_t / bank_sel_f : splits a word address into bank index and row.
//   SRAM_IS_POW2 / SRAM_CHECK : elaboration-time parameter checks.

`ifndef SRAM_PKG_MACROS
`define SRAM_PKG_MACROS
`define SRAM_IS_POW2(v) (((v) > 0) && ((((v) - 1) & (v)) == 0))
`define SRAM_CHECK(cond, lbl, msg) if (!(cond)) begin : lbl $error(msg); end
`endif

package sram_pkg;

    // Fields are wide enough for any address this block will ever see.
    // Callers truncate them to their own BANK_W / ROW_W.
    typedef struct packed {
        logic [31:0] bank;
        logic [31:0] row;
    } bank_sel_t;

    // Low address bits pick the bank, the remaining bits pick the row.
    function automatic bank_sel_t bank_sel_f(input logic [31:0] addr,
                                             input int unsigned bank_w);
        bank_sel_t s;
        s.bank = addr & ((32'd1 << bank_w) - 32'd1);
        s.row  = addr >> bank_w;
        return s;
    endfunction

endpackage

// File: rtl/sram_1rw_bank.sv
// Single-port (1RW) bank.
// This file is the behavioural model used in simulation. In the ASIC flow the
// module is a blackbox and is replaced by a hardened macro.
//   clk  : clock
//   en   : access enable
//   we   : 1 = write, 0 = read
//   be   : byte enables for writes
//   addr : row address
//   din  : write data
//   dout : read data, registered, valid the cycle after a read

`ifdef ASIC_SYNTHESIS
(* blackbox *)
`endif
module sram_1rw_bank #(
    parameter int DATA_W = 32,
    parameter int ROWS   = 2048,
    localparam int AW    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                clk,
    input  logic                en,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [AW-1:0]       addr,
    input  logic [DATA_W-1:0]   din,
    output logic [DATA_W-1:0]   dout
);

    logic [DATA_W-1:0] mem [ROWS];

    // A write leaves dout unchanged, which matches the hardened macro.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < DATA_W / 8; i++) begin
                    if (be[i]) begin
                        mem[addr][i*8 +: 8] <= din[i*8 +: 8];
                    end
                end
            end else begin
                dout <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/sram_banked_dp.sv
// Logical dual-port SRAM built from NUM_BANKS single-port banks.
// Words are interleaved across the banks on the low word-address bits.
// If both ports request the same bank in one cycle, an alternating-priority
// arbiter grants one port, and the other port stalls.
//   clk, rst                       : clock, async active-high reset
//   a_req / a_gnt                  : request, combinational grant
//   a_we, a_be, a_addr, a_wdata    : command (write when a_we)
//   a_rvalid, a_rdata              : read response, 1-cycle latency; rdata holds
//   b_*                            : same set of signals for port B

module sram_banked_dp
    import sram_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 8192,
    parameter int NUM_BANKS = 4,
    parameter int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                a_req,
    output logic                a_gnt,
    input  logic                a_we,
    input  logic [DATA_W/8-1:0] a_be,
    input  logic [ADDR_W-1:0]   a_addr,
    input  logic [DATA_W-1:0]   a_wdata,
    output logic                a_rvalid,
    output logic [DATA_W-1:0]   a_rdata,

    input  logic                b_req,
    output logic                b_gnt,
    input  logic                b_we,
    input  logic [DATA_W/8-1:0] b_be,
    input  logic [ADDR_W-1:0]   b_addr,
    input  logic [DATA_W-1:0]   b_wdata,
    output logic                b_rvalid,
    output logic [DATA_W-1:0]   b_rdata
);

    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int ROWS   = DEPTH / NUM_BANKS;
    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

    `SRAM_CHECK((DATA_W % 8) == 0 && DATA_W > 0, g_chk_data_w, "DATA_W must be a positive multiple of 8")
    `SRAM_CHECK(`SRAM_IS_POW2(DEPTH), g_chk_depth, "DEPTH must be a power of 2")
    `SRAM_CHECK(`SRAM_IS_POW2(NUM_BANKS) && NUM_BANKS >= 2 && NUM_BANKS <= DEPTH,
                g_chk_banks, "NUM_BANKS must be a power of 2 in [2, DEPTH]")
    `SRAM_CHECK(ADDR_W == $clog2(DEPTH), g_chk_addr_w, "ADDR_W is derived from DEPTH")

    bank_sel_t          a_sel, b_sel;
    logic [BANK_W-1:0]  a_bank, b_bank;
    logic [ROW_W-1:0]   a_row, b_row;
    logic               conflict;
    logic               a_acc, b_acc;
    logic               prio_b;

    always_comb begin
        a_sel  = bank_sel_f(32'(a_addr), BANK_W);
        b_sel  = bank_sel_f(32'(b_addr), BANK_W);
        a_bank = BANK_W'(a_sel.bank);
        b_bank = BANK_W'(b_sel.bank);
        a_row  = ROW_W'(a_sel.row);
        b_row  = ROW_W'(b_sel.row);
    end

    // Conflict is decided on the bank field alone; the rows do not matter.
    assign conflict = a_req && b_req && (a_bank == b_bank);
    assign a_gnt    = !conflict || !prio_b;
    assign b_gnt    = !conflict ||  prio_b;
    assign a_acc    = a_req && a_gnt;
    assign b_acc    = b_req && b_gnt;

    // Toggling on every conflict makes the loser win the next conflict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_b <= 1'b0;
        end else if (conflict) begin
            prio_b <= ~prio_b;
        end
    end

    logic [NUM_BANKS-1:0] bank_en;
    logic [NUM_BANKS-1:0] bank_we;
    logic [DATA_W/8-1:0]  bank_be   [NUM_BANKS];
    logic [ROW_W-1:0]     bank_row  [NUM_BANKS];
    logic [DATA_W-1:0]    bank_din  [NUM_BANKS];
    logic [DATA_W-1:0]    bank_dout [NUM_BANKS];

    for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
        logic a_hit, b_hit;

        // At most one port is accepted per bank, so B selects the bank inputs
        // only when B is the port that hits this bank.
        assign a_hit       = a_acc && (a_bank == BANK_W'(k));
        assign b_hit       = b_acc && (b_bank == BANK_W'(k));
        assign bank_en[k]  = a_hit || b_hit;
        assign bank_we[k]  = b_hit ? b_we    : a_we;
        assign bank_be[k]  = b_hit ? b_be    : a_be;
        assign bank_row[k] = b_hit ? b_row   : a_row;
        assign bank_din[k] = b_hit ? b_wdata : a_wdata;

        sram_1rw_bank #(
            .DATA_W (DATA_W),
            .ROWS   (ROWS)
        ) u_bank (
            .clk  (clk),
            .en   (bank_en[k]),
            .we   (bank_we[k]),
            .be   (bank_be[k]),
            .addr (bank_row[k]),
            .din  (bank_din[k]),
            .dout (bank_dout[k])
        );
    end

    logic [BANK_W-1:0] a_pend_bank, b_pend_bank;
    logic [DATA_W-1:0] a_hold, b_hold;

    // rvalid is the pending-read flag. The bank output is valid during the
    // rvalid cycle, and the hold register captures it at the end of that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rvalid    <= 1'b0;
            b_rvalid    <= 1'b0;
            a_pend_bank <= '0;
            b_pend_bank <= '0;
            a_hold      <= '0;
            b_hold      <= '0;
        end else begin
            a_rvalid <= a_acc && !a_we;
            b_rvalid <= b_acc && !b_we;
            if (a_acc && !a_we) a_pend_bank <= a_bank;
            if (b_acc && !b_we) b_pend_bank <= b_bank;
            if (a_rvalid) a_hold <= bank_dout[a_pend_bank];
            if (b_rvalid) b_hold <= bank_dout[b_pend_bank];
        end
    end

    assign a_rdata = a_rvalid ? bank_dout[a_pend_bank] : a_hold;
    assign b_rdata = b_rvalid ? bank_dout[b_pend_bank] : b_hold;

endmodule

// File: tb/tb_sram_banked_dp.sv
module tb_sram_banked_dp;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 8192;
    localparam int NB     = 4;
    localparam int AW     = 13;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [3:0]        a_be = 4'h0, b_be = 4'h0;
    logic [AW-1:0]     a_addr = '0, b_addr = '0;
    logic [DATA_W-1:0] a_wdata = '0, b_wdata = '0;
    logic              a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [DATA_W-1:0] a_rdata, b_rdata;

    int errors = 0;
    int checks = 0;

    sram_banked_dp #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_BANKS(NB)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_gnt(a_gnt), .a_we(a_we), .a_be(a_be), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_gnt(b_gnt), .b_we(b_we), .b_be(b_be), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_req = 1'b0; a_we = 1'b0; a_be = 4'h0;
        b_req = 1'b0; b_we = 1'b0; b_be = 4'h0;
    endtask

    task automatic a_cmd(input logic we, input logic [3:0] be, input logic [AW-1:0] addr,
                         input logic [31:0] d);
        a_req = 1'b1; a_we = we; a_be = be; a_addr = addr; a_wdata = d;
    endtask

    task automatic b_cmd(input logic we, input logic [3:0] be, input logic [AW-1:0] addr,
                         input logic [31:0] d);
        b_req = 1'b1; b_we = we; b_be = be; b_addr = addr; b_wdata = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL reset_a_rvalid got=%b exp=0", a_rvalid); end
            checks++; if (b_rvalid !== 1'b0) begin errors++; $display("FAIL reset_b_rvalid got=%b exp=0", b_rvalid); end
            checks++; if (a_rdata !== 32'h0) begin errors++; $display("FAIL reset_a_rdata got=%h exp=0", a_rdata); end
            checks++; if (b_rdata !== 32'h0) begin errors++; $display("FAIL reset_b_rdata got=%h exp=0", b_rdata); end
        end
        rst = 1'b0;
        #1;
        checks++; if (a_gnt !== 1'b1) begin errors++; $display("FAIL idle_a_gnt got=%b exp=1", a_gnt); end
        checks++; if (b_gnt !== 1'b1) begin errors++; $display("FAIL idle_b_gnt got=%b exp=1", b_gnt); end
        step();
    endtask

    task automatic test_write_read();
        a_cmd(1'b1, 4'hF, 13'h005, 32'hDEADBEEF);
        #1;
        checks++; if (a_gnt !== 1'b1) begin errors++; $display("FAIL wr_a_gnt got=%b exp=1", a_gnt); end
        step();
        checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid got=%b exp=0", a_rvalid); end
        a_cmd(1'b0, 4'h0, 13'h005, 32'h0);
        step();
        idle();
        checks++; if (a_rvalid !== 1'b1) begin errors++; $display("FAIL rd_a_rvalid got=%b exp=1", a_rvalid); end
        checks++; if (a_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_a_rdata got=%h exp=deadbeef", a_rdata); end
        step();
        checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL rd_pulse got=%b exp=0", a_rvalid); end
        checks++; if (a_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_hold got=%h exp=deadbeef", a_rdata); end
    endtask

    task automatic test_byte_enables();
        b_cmd(1'b1, 4'hF, 13'h010, 32'hAAAAAAAA);
        step();
        b_cmd(1'b1, 4'b0101, 13'h010, 32'h11223344);
        step();
        b_cmd(1'b0, 4'h0, 13'h010, 32'h0);
        step();
        idle();
        checks++; if (b_rvalid !== 1'b1) begin errors++; $display("FAIL be_b_rvalid got=%b exp=1", b_rvalid); end
        checks++; if (b_rdata !== 32'hAA22AA44) begin errors++; $display("FAIL be_b_rdata got=%h exp=aa22aa44", b_rdata); end
        step();
    endtask

    task automatic test_parallel();
        a_cmd(1'b1, 4'hF, 13'h004, 32'h04040404);
        b_cmd(1'b1, 4'hF, 13'h001, 32'h01010101);
        step();
        a_cmd(1'b0, 4'h0, 13'h004, 32'h0);
        b_cmd(1'b0, 4'h0, 13'h001, 32'h0);
        #1;
        checks++; if (a_gnt !== 1'b1) begin errors++; $display("FAIL par_a_gnt got=%b exp=1", a_gnt); end
        checks++; if (b_gnt !== 1'b1) begin errors++; $display("FAIL par_b_gnt got=%b exp=1", b_gnt); end
        step();
        idle();
        checks++; if (a_rvalid !== 1'b1) begin errors++; $display("FAIL par_a_rvalid got=%b exp=1", a_rvalid); end
        checks++; if (b_rvalid !== 1'b1) begin errors++; $display("FAIL par_b_rvalid got=%b exp=1", b_rvalid); end
        checks++; if (a_rdata !== 32'h04040404) begin errors++; $display("FAIL par_a_rdata got=%h exp=04040404", a_rdata); end
        checks++; if (b_rdata !== 32'h01010101) begin errors++; $display("FAIL par_b_rdata got=%h exp=01010101", b_rdata); end
        step();
    endtask

    task automatic test_conflict();
        logic [3:0] exp_a;
        exp_a = 4'b0101;  // bit i = 1 when A wins conflict cycle i
        a_cmd(1'b1, 4'hF, 13'h002, 32'h22222222);
        step();
        idle();
        b_cmd(1'b1, 4'hF, 13'h006, 32'h66666666);
        step();
        a_cmd(1'b0, 4'h0, 13'h002, 32'h0);
        b_cmd(1'b0, 4'h0, 13'h006, 32'h0);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (a_gnt !== exp_a[i]) begin errors++; $display("FAIL cf_a_gnt cyc=%0d got=%b exp=%b", i, a_gnt, exp_a[i]); end
            checks++; if (b_gnt !== !exp_a[i]) begin errors++; $display("FAIL cf_b_gnt cyc=%0d got=%b exp=%b", i, b_gnt, !exp_a[i]); end
            step();
            checks++; if (a_rvalid !== exp_a[i]) begin errors++; $display("FAIL cf_a_rvalid cyc=%0d got=%b exp=%b", i, a_rvalid, exp_a[i]); end
            checks++; if (b_rvalid !== !exp_a[i]) begin errors++; $display("FAIL cf_b_rvalid cyc=%0d got=%b exp=%b", i, b_rvalid, !exp_a[i]); end
            if (exp_a[i]) begin
                checks++; if (a_rdata !== 32'h22222222) begin errors++; $display("FAIL cf_a_rdata cyc=%0d got=%h exp=22222222", i, a_rdata); end
            end else begin
                checks++; if (b_rdata !== 32'h66666666) begin errors++; $display("FAIL cf_b_rdata cyc=%0d got=%h exp=66666666", i, b_rdata); end
            end
        end
        idle();
        step();
    endtask

    task automatic test_cross_port();
        a_cmd(1'b1, 4'hF, 13'h003, 32'h00000005);
        step();
        idle();
        b_cmd(1'b0, 4'h0, 13'h003, 32'h0);
        step();
        idle();
        checks++; if (b_rvalid !== 1'b1) begin errors++; $display("FAIL xp_b_rvalid got=%b exp=1", b_rvalid); end
        checks++; if (b_rdata !== 32'h00000005) begin errors++; $display("FAIL xp_b_rdata got=%h exp=00000005", b_rdata); end
        step();
    endtask

    task automatic test_reset_mid_read();
        a_cmd(1'b0, 4'h0, 13'h004, 32'h0);
        step();
        idle();
        rst = 1'b1;
        #1;
        checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL rmr_a_rvalid got=%b exp=0", a_rvalid); end
        checks++; if (a_rdata !== 32'h0) begin errors++; $display("FAIL rmr_a_rdata got=%h exp=0", a_rdata); end
        step();
        rst = 1'b0;
        step();
        checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL rmr_after_rvalid got=%b exp=0", a_rvalid); end
        checks++; if (a_rdata !== 32'h0) begin errors++; $display("FAIL rmr_after_rdata got=%h exp=0", a_rdata); end
        a_cmd(1'b0, 4'h0, 13'h005, 32'h0);
        step();
        idle();
        checks++; if (a_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rmr_retained got=%h exp=deadbeef", a_rdata); end
        step();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_enables();
        test_parallel();
        test_conflict();
        test_cross_port();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
